// File: rtl/move_collector.sv
// Drains the per-square move FIFOs once every square unit reports done and
// serialises the valid move slots of each popped word onto a ready/valid stream.
module move_collector #(
  parameter int unsigned NSQ    = 64,
  parameter int unsigned SLOTS  = 8,
  parameter int unsigned MOVE_W = 19,
  parameter int unsigned WORD_W = 160,
  parameter int unsigned CNT_W  = 12
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [NSQ-1:0]          sq_done,
  input  logic [NSQ-1:0]          sq_empty,
  input  logic [NSQ*WORD_W-1:0]   sq_data,
  output logic [NSQ-1:0]          sq_rden,
  output logic                    mv_valid,
  output logic [MOVE_W-1:0]       mv_data,
  input  logic                    mv_ready,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        move_cnt
);

  localparam int unsigned IDX_W  = (NSQ > 1) ? $clog2(NSQ) : 1;
  localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned USED_W = SLOTS * MOVE_W;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SCAN, S_READ, S_LATCH, S_UNPK, S_FIN
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [USED_W-1:0]   word_q, word_d;
  logic                mv_valid_q, mv_valid_d;
  logic [MOVE_W-1:0]   mv_data_q, mv_data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [MOVE_W-1:0]   slot_arr [SLOTS];
  logic [MOVE_W-1:0]   cur_slot;
  logic                pad_unused;

  always_comb begin
    for (int unsigned k = 0; k < SLOTS; k++) begin
      slot_arr[k] = word_q[k*MOVE_W +: MOVE_W];
    end
    cur_slot = slot_arr[slot_q];
  end

  // Pad bits above the move slots carry no information.
  always_comb begin
    pad_unused = 1'b0;
    for (int unsigned i = 0; i < NSQ; i++) begin
      pad_unused = pad_unused ^ (^sq_data[i*WORD_W+USED_W +: WORD_W-USED_W]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      slot_q     <= SLOT_W'(SLOTS-1);
      word_q     <= '0;
      mv_valid_q <= 1'b0;
      mv_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      slot_q     <= slot_d;
      word_q     <= word_d;
      mv_valid_q <= mv_valid_d;
      mv_data_q  <= mv_data_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    slot_d     = slot_q;
    word_d     = word_q;
    mv_valid_d = mv_valid_q;
    mv_data_d  = mv_data_q;
    cnt_d      = cnt_q;
    sq_rden    = '0;
    done       = 1'b0;

    if (mv_valid_q && mv_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (&sq_done) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (!sq_empty[idx_q]) begin
          state_d = S_READ;
        end else if (idx_q == IDX_W'(NSQ-1)) begin
          state_d = S_FIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_READ: begin
        sq_rden[idx_q] = 1'b1;
        state_d        = S_LATCH;
      end
      S_LATCH: begin
        word_d  = sq_data[32'(idx_q)*WORD_W +: USED_W];
        slot_d  = SLOT_W'(SLOTS-1);
        state_d = S_UNPK;
      end
      S_UNPK: begin
        // A valid slot is registered onto mv_data first, then held until accepted;
        // the slot pointer only advances once the slot is skipped or transferred.
        if (mv_valid_q) begin
          if (mv_ready) begin
            mv_valid_d = 1'b0;
            if (slot_q == '0) state_d = S_SCAN;
            else              slot_d  = slot_q - SLOT_W'(1);
          end
        end else if (cur_slot[MOVE_W-1]) begin
          if (slot_q == '0) state_d = S_SCAN;
          else              slot_d  = slot_q - SLOT_W'(1);
        end else begin
          mv_valid_d = 1'b1;
          mv_data_d  = cur_slot;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mv_valid = mv_valid_q;
  assign mv_data  = mv_data_q;
  assign move_cnt = cnt_q;
  assign busy     = (state_q != S_IDLE);

endmodule
